// File: rtl/ball_motion.sv
// Pong ball kinematics: serve/move/miss FSM, wall and paddle reflection, one step per frame.
// Optional macro BALL_MOTION_SPEEDUP_EN: each paddle hit raises speed by 1 up to BALL_SPEED_MAX.
module ball_motion #(
  parameter int GRAPHICS_WIDTH   = 1280,
  parameter int GRAPHICS_HEIGHT  = 800,
  parameter int BORDER_WIDTH     = 50,
  parameter int BALL_RADIUS      = 16,
  parameter int PADDLE_WIDTH     = 20,
  parameter int PADDLE_LENGTH    = 200,
  parameter int BALL_SPEED       = 4,
  parameter int BALL_SPEED_MAX   = 12,
  parameter int POSITION_REG_MAX = 11
) (
  input  logic                      pixel_clock,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      serve,
  input  logic [POSITION_REG_MAX:0] paddle_x,
  input  logic [POSITION_REG_MAX:0] paddle_y,
  output logic [POSITION_REG_MAX:0] ball_x,
  output logic [POSITION_REG_MAX:0] ball_y,
  output logic                      ball_active,
  output logic                      hit,
  output logic                      miss,
  output logic [3:0]                speed,
  output logic [1:0]                fsm_state
);

  typedef logic [POSITION_REG_MAX:0]   pos_t;
  typedef logic [POSITION_REG_MAX+1:0] wide_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_MISS = 2'd2} state_t;

  localparam pos_t CENTRE_X = pos_t'(GRAPHICS_WIDTH / 2);
  localparam pos_t CENTRE_Y = pos_t'(GRAPHICS_HEIGHT / 2);
  localparam pos_t LIM_LO   = pos_t'(BORDER_WIDTH + BALL_RADIUS);
  localparam pos_t LIM_BOT  = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_RADIUS);
  localparam pos_t LIM_RGT  = pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH - BALL_RADIUS);

  state_t state, state_n;
  logic   dir_x, dir_y;       // dir_x: 1 = right; dir_y: 1 = down
  logic   serve_toggle;
  logic   launch, step, recentre;

  // Boundary decisions are made one bit wider so sums never wrap;
  // the narrow next-position math only runs when the compare proved it safe.
  wide_t x_w, y_w, s_w, face_w, pad_top_w, pad_bot_w;
  pos_t  x_n, y_n;
  logic  dx_n, dy_n, hit_c, miss_c, on_paddle;

  assign fsm_state   = state;
  assign ball_active = (state == S_MOVE);

  always_comb begin
    x_w       = {1'b0, ball_x};
    y_w       = {1'b0, ball_y};
    s_w       = wide_t'(speed);
    face_w    = {1'b0, paddle_x} + wide_t'(PADDLE_WIDTH + BALL_RADIUS);
    pad_top_w = {1'b0, paddle_y};
    pad_bot_w = {1'b0, paddle_y} + wide_t'(PADDLE_LENGTH);
    on_paddle = (y_w >= pad_top_w) && (y_w <= pad_bot_w);
    x_n       = ball_x;
    y_n       = ball_y;
    dx_n      = dir_x;
    dy_n      = dir_y;
    hit_c     = 1'b0;
    miss_c    = 1'b0;

    if (dir_y) begin
      if (y_w + s_w > wide_t'(LIM_BOT)) begin
        y_n  = LIM_BOT;
        dy_n = 1'b0;
      end else begin
        y_n = ball_y + pos_t'(speed);
      end
    end else begin
      if (y_w < wide_t'(LIM_LO) + s_w) begin
        y_n  = LIM_LO;
        dy_n = 1'b1;
      end else begin
        y_n = ball_y - pos_t'(speed);
      end
    end

    if (dir_x) begin
      if (x_w + s_w > wide_t'(LIM_RGT)) begin
        x_n  = LIM_RGT;
        dx_n = 1'b0;
      end else begin
        x_n = ball_x + pos_t'(speed);
      end
    end else if (x_w >= face_w && x_w < face_w + s_w && on_paddle) begin
      x_n   = face_w[POSITION_REG_MAX:0];
      dx_n  = 1'b1;
      hit_c = 1'b1;
    end else if (x_w < wide_t'(LIM_LO) + s_w) begin
      x_n    = LIM_LO;
      miss_c = 1'b1;
    end else begin
      x_n = ball_x - pos_t'(speed);
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    launch   = 1'b0;
    step     = 1'b0;
    recentre = 1'b0;
    case (state)
      S_IDLE: if (serve) begin
        state_n = S_MOVE;
        launch  = 1'b1;
      end
      S_MOVE: if (frame_tick) begin
        step = 1'b1;
        if (miss_c) state_n = S_MISS;
      end
      S_MISS: begin
        state_n  = S_IDLE;
        recentre = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      ball_x       <= CENTRE_X;
      ball_y       <= CENTRE_Y;
      dir_x        <= 1'b0;
      dir_y        <= 1'b0;
      serve_toggle <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (launch) begin
        dir_x        <= 1'b0;
        dir_y        <= serve_toggle;
        serve_toggle <= ~serve_toggle;
      end
      if (step) begin
        ball_x <= x_n;
        ball_y <= y_n;
        dir_x  <= dx_n;
        dir_y  <= dy_n;
        hit    <= hit_c;
        miss   <= miss_c;
      end
      if (recentre) begin
        ball_x <= CENTRE_X;
        ball_y <= CENTRE_Y;
      end
    end
  end

`ifdef BALL_MOTION_SPEEDUP_EN
  logic [3:0] spd;
  assign speed = spd;
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      spd <= 4'(BALL_SPEED);
    end else if (launch || recentre) begin
      spd <= 4'(BALL_SPEED);
    end else if (step && hit_c && spd < 4'(BALL_SPEED_MAX)) begin
      spd <= spd + 4'd1;
    end
  end
`else
  assign speed = 4'(BALL_SPEED);
`endif

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: launch, wall reflections, paddle hit, miss, reset behaviour.
module tb_ball_motion;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        serve = 1'b0;
  logic [11:0] paddle_x = 12'd110;
  logic [11:0] paddle_y = 12'd1000;
  logic [11:0] ball_x, ball_y;
  logic        ball_active, hit, miss;
  logic [3:0]  speed;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit do_serve;
    int ticks;
    int py;
    int ex;
    int ey;
    bit eact;
    int est;
  } vec_t;

  vec_t launch_tbl[$];
  vec_t bounce_tbl[$];

  ball_motion dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .serve       (serve),
    .paddle_x    (paddle_x),
    .paddle_y    (paddle_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_active (ball_active),
    .hit         (hit),
    .miss        (miss),
    .speed       (speed),
    .fsm_state   (fsm_state)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string name, input int ex, input int ey);
    check({name, ".x"}, int'(ball_x), ex);
    check({name, ".y"}, int'(ball_y), ey);
  endtask

  task automatic tick();
    @(negedge pixel_clock) frame_tick = 1'b1;
    @(negedge pixel_clock) frame_tick = 1'b0;
  endtask

  task automatic serve_pulse();
    @(negedge pixel_clock) serve = 1'b1;
    @(negedge pixel_clock) serve = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pixel_clock) reset = 1'b1;
    repeat (2) @(negedge pixel_clock);
    reset = 1'b0;
    @(negedge pixel_clock);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    paddle_y = 12'(v.py);
    if (v.do_serve) serve_pulse();
    repeat (v.ticks) tick();
    check_pos($sformatf("vec%0d", idx), v.ex, v.ey);
    check($sformatf("vec%0d.active", idx), int'(ball_active), int'(v.eact));
    check($sformatf("vec%0d.state", idx), int'(fsm_state), v.est);
  endtask

  initial begin
    // serve, ticks, paddle_y, x, y, active, state
    launch_tbl.push_back('{1, 0,  1000, 640, 400, 1, 1});
    launch_tbl.push_back('{0, 1,  1000, 636, 396, 1, 1});
    launch_tbl.push_back('{0, 82, 1000, 308, 68,  1, 1});
    launch_tbl.push_back('{0, 1,  1000, 304, 66,  1, 1});
    launch_tbl.push_back('{0, 1,  1000, 300, 70,  1, 1});
    launch_tbl.push_back('{1, 37, 200,  152, 218, 1, 1});
    launch_tbl.push_back('{0, 1,  200,  148, 222, 1, 1});

    bounce_tbl.push_back('{0, 127, 200, 654,  734, 1, 1});
    bounce_tbl.push_back('{0, 1,   200, 658,  734, 1, 1});
    bounce_tbl.push_back('{0, 139, 200, 1214, 178, 1, 1});
    bounce_tbl.push_back('{0, 1,   200, 1214, 174, 1, 1});
    bounce_tbl.push_back('{0, 27,  200, 1106, 66,  1, 1});
    bounce_tbl.push_back('{0, 1,   200, 1102, 66,  1, 1});
    bounce_tbl.push_back('{0, 1,   200, 1098, 70,  1, 1});

    // Reset state
    repeat (2) @(negedge pixel_clock);
    check_pos("reset", 640, 400);
    check("reset.active", int'(ball_active), 0);
    check("reset.hit", int'(hit), 0);
    check("reset.miss", int'(miss), 0);
    check("reset.speed", int'(speed), 4);
    check("reset.state", int'(fsm_state), 0);
    reset = 1'b0;
    @(negedge pixel_clock);

    // Launch, top-wall reflection, approach to the paddle (mid-flight serve ignored)
    for (int i = 0; i < launch_tbl.size(); i++) apply_vec(launch_tbl[i], i);

    // Paddle hit: face at 110+20+16=146, y=222 within [200,400]
    tick();
    check_pos("hit", 146, 226);
    check("hit.pulse", int'(hit), 1);
    check("hit.miss", int'(miss), 0);
`ifdef BALL_MOTION_SPEEDUP_EN
    check("hit.speed", int'(speed), 5);
`else
    check("hit.speed", int'(speed), 4);
`endif
    @(negedge pixel_clock);
    check("hit.pulse_end", int'(hit), 0);

`ifndef BALL_MOTION_SPEEDUP_EN
    // Bottom, right and top reflections at constant speed
    for (int i = 0; i < bounce_tbl.size(); i++) apply_vec(bounce_tbl[i], 100 + i);
`endif

    // Miss: paddle out of the ball's path
    do_reset();
    paddle_y = 12'd600;
    serve_pulse();
    repeat (143) tick();
    check_pos("pre_miss", 68, 302);
    tick();
    check_pos("miss", 66, 306);
    check("miss.pulse", int'(miss), 1);
    check("miss.hit", int'(hit), 0);
    check("miss.state", int'(fsm_state), 2);
    check("miss.active", int'(ball_active), 0);
    @(negedge pixel_clock);
    check("miss.pulse_end", int'(miss), 0);
    check("miss.idle", int'(fsm_state), 0);
    check_pos("miss.recentre", 640, 400);
    check("miss.speed", int'(speed), 4);

    // Second serve after reset launches downward
    serve_pulse();
    tick();
    check_pos("serve2", 636, 404);

    // IDLE ignores frame_tick; serve with frame_tick launches without moving
    do_reset();
    paddle_y = 12'd1000;
    tick();
    check_pos("idle_tick", 640, 400);
    check("idle_tick.state", int'(fsm_state), 0);
    @(negedge pixel_clock);
    serve = 1'b1;
    frame_tick = 1'b1;
    @(negedge pixel_clock);
    serve = 1'b0;
    frame_tick = 1'b0;
    check_pos("serve_tick", 640, 400);
    check("serve_tick.active", int'(ball_active), 1);
    repeat (10) tick();
    check_pos("flight", 600, 360);

    // Asynchronous reset mid-flight with serve held
    @(negedge pixel_clock);
    serve = 1'b1;
    reset = 1'b1;
    #1;
    check_pos("async_rst", 640, 400);
    check("async_rst.active", int'(ball_active), 0);
    check("async_rst.state", int'(fsm_state), 0);
    repeat (2) @(negedge pixel_clock);
    check("rst_hold.active", int'(ball_active), 0);
    check("rst_hold.hit", int'(hit), 0);
    check("rst_hold.miss", int'(miss), 0);
    reset = 1'b0;
    serve = 1'b0;
    @(negedge pixel_clock);
    check("post_rst.state", int'(fsm_state), 0);
    check_pos("post_rst", 640, 400);
    serve_pulse();
    tick();
    check_pos("post_rst_serve", 636, 396);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
